// File: rtl/stream_mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_pkg
//  Purpose  : Shared types and helpers for the stream_mux_arb block.
//             Provides the packet-lock state encoding, the mode selector
//             constants, and a clog2 helper that never returns less than 1.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package stream_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width for n items. A one-bit index is the minimum, so the
  // result for n = 2 (and the degenerate n = 1) is 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_arb_if
//  Purpose  : Bundles the producer-side and consumer-side handshake signals
//             of the stream multiplexer.
//  Ports    : in_valid/in_data/in_last/in_ready  - N producer channels
//             sel                                - external channel select
//             out_valid/out_data/out_last/out_sel/out_ready - consumer side
//  Modports : master - environment side (drives producers and out_ready)
//             slave  - multiplexer side
//  Revision : 1.0  initial release
// ============================================================================
interface stream_mux_arb_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import stream_mux_pkg::*;

  localparam int SELW = clog2(N);

  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [SELW-1:0] out_sel;
  logic            out_ready;

  modport master (
    output in_valid, in_data, in_last, sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, sel, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

endinterface
`default_nettype wire

// File: rtl/stream_mux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Returns the first requesting
//             index found when searching upward from ptr, wrapping mod N.
//  Ports    : req[N]        request vector
//             ptr[SELW]     search start index (expected < N)
//             gnt_valid     at least one request present
//             gnt_idx[SELW] winning index
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = SELW'((int'(ptr) + k) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_arb
//  Purpose  : N:1 W-bit stream multiplexer with valid/ready on every port.
//             Channel choice is either an external select (MODE=0) or
//             round-robin (MODE=1). With LOCK_PKT=1 the grant is held from
//             the first beat of a packet until its in_last beat. The chosen
//             beat is registered, giving one cycle of latency and full
//             throughput.
//  Ports    : clk        rising-edge clock
//             rst        synchronous active-high reset
//             bus.slave  in_valid/in_data/in_last/in_ready (N channels),
//                        sel, out_valid/out_data/out_last/out_sel/out_ready
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MODE     = 1,
  parameter int LOCK_PKT = 1
) (
  input  logic           clk,
  input  logic           rst,
  stream_mux_arb_if.slave bus
);

  localparam int SELW = clog2(N);

  // Registered state
  state_e          state_q,     state_d;
  logic [SELW-1:0] lock_ch_q,   lock_ch_d;
  logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic            out_last_q,  out_last_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;

  // Combinational
  logic            load;
  logic            arb_valid;
  logic [SELW-1:0] arb_idx;
  logic            grant_valid;
  logic [SELW-1:0] grant_idx;
  logic [N-1:0]    ready_vec;
  logic            xfer;
  logic [W-1:0]    chan_data [N];

  // Unpack the flat data bus so the selected beat is a plain array lookup.
  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan_data[i] = bus.in_data[i*W +: W];
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // The output register can take a new beat when empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (state_q == LOCK) begin
      // Mid-packet: the locked channel owns the port even while it idles,
      // so a gap in its packet becomes a bubble rather than a hand-over.
      grant_valid = 1'b1;
      grant_idx   = lock_ch_q;
    end else if (MODE == MODE_RR) begin
      grant_valid = arb_valid;
      grant_idx   = arb_idx;
    end else if (int'(bus.sel) < N) begin
      grant_valid = bus.in_valid[bus.sel];
      grant_idx   = bus.sel;
    end
  end

  // Ready is a pure decode of the grant, so it cannot depend on any other
  // channel's ready and is one-hot or zero.
  always_comb begin
    ready_vec = '0;
    if (!rst && load && grant_valid) ready_vec[grant_idx] = 1'b1;
  end

  assign bus.in_ready = ready_vec;
  assign xfer         = |(bus.in_valid & ready_vec);

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = chan_data[grant_idx];
        out_last_d = bus.in_last[grant_idx];
        out_sel_d  = grant_idx;
      end
    end

    if (LOCK_PKT != 0 && xfer) begin
      case (state_q)
        IDLE: begin
          if (!bus.in_last[grant_idx]) begin
            state_d   = LOCK;
            lock_ch_d = grant_idx;
          end
        end
        LOCK: begin
          if (bus.in_last[grant_idx]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // The pointer only advances once a whole packet (or any beat when not
    // locking) has gone, so the next search starts just past the winner.
    if (MODE == MODE_RR && xfer && (LOCK_PKT == 0 || bus.in_last[grant_idx])) begin
      if (grant_idx == SELW'(N-1)) rr_ptr_d = '0;
      else                         rr_ptr_d = grant_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_arb
//  Purpose  : Directed self-checking bench for stream_mux_arb. Three
//             instances: A = round-robin, no lock (N=4); B = round-robin with
//             packet lock (N=4); C = external select with lock (N=5, so an
//             out-of-range select is expressible).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_arb;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux_arb_if #(.N(4), .W(8)) ifa ();
  stream_mux_arb_if #(.N(4), .W(8)) ifb ();
  stream_mux_arb_if #(.N(5), .W(8)) ifc ();

  stream_mux_arb #(.N(4), .W(8), .MODE(1), .LOCK_PKT(0)) u_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  stream_mux_arb #(.N(4), .W(8), .MODE(1), .LOCK_PKT(1)) u_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );
  stream_mux_arb #(.N(5), .W(8), .MODE(0), .LOCK_PKT(1)) u_c (
    .clk (clk), .rst (rst), .bus (ifc.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sample one time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- Reset with every channel asserting valid ----------
    rst           = 1'b1;
    ifa.in_valid  = 4'b1111;
    ifa.in_last   = 4'b1111;
    ifa.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    ifa.sel       = '0;
    ifa.out_ready = 1'b1;
    ifb.in_valid  = 4'b1111;
    ifb.in_last   = 4'b1111;
    ifb.in_data   = '0;
    ifb.sel       = '0;
    ifb.out_ready = 1'b1;
    ifc.in_valid  = 5'b11111;
    ifc.in_last   = 5'b11111;
    ifc.in_data   = '0;
    ifc.sel       = '0;
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_in_ready",  32'(ifa.in_ready),  32'h0);
    chk("rst_b_in_ready",  32'(ifb.in_ready),  32'h0);
    chk("rst_c_in_ready",  32'(ifc.in_ready),  32'h0);
    chk("rst_a_out_valid", 32'(ifa.out_valid), 32'h0);
    chk("rst_a_out_sel",   32'(ifa.out_sel),   32'h0);
    chk("rst_b_out_valid", 32'(ifb.out_valid), 32'h0);
    chk("rst_c_out_valid", 32'(ifc.out_valid), 32'h0);

    // ---------------- Round-robin fairness, no lock (A) -----------------
    rst          = 1'b0;
    ifb.in_valid = '0;
    ifc.in_valid = '0;
    #1;
    chk("rr_ready_first", 32'(ifa.in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_valid_%0d", k), 32'(ifa.out_valid), 32'h1);
      chk($sformatf("rr_sel_%0d", k),   32'(ifa.out_sel),   32'(k % 4));
      chk($sformatf("rr_data_%0d", k),  32'(ifa.out_data),  32'(8'h10 + k % 4));
      chk($sformatf("rr_ready_%0d", k), 32'(ifa.in_ready),  32'(1 << ((k + 1) % 4)));
    end
    ifa.in_valid = '0;

    // ---------------- Packet lock on ch1 while ch2 waits (B) ------------
    ifb.in_data[8 +: 8]  = 8'hB1;
    ifb.in_data[16 +: 8] = 8'hC2;
    ifb.in_last  = 4'b0100;
    ifb.in_valid = 4'b0110;
    #1;
    chk("lk_ready_b1", 32'(ifb.in_ready), 32'h2);
    tick();
    chk("lk_valid_b1", 32'(ifb.out_valid), 32'h1);
    chk("lk_sel_b1",   32'(ifb.out_sel),   32'h1);
    chk("lk_data_b1",  32'(ifb.out_data),  32'hB1);
    chk("lk_last_b1",  32'(ifb.out_last),  32'h0);
    ifb.in_valid = 4'b0100;                 // ch1 bubble, ch2 still asking
    #1;
    chk("lk_ready_bubble", 32'(ifb.in_ready), 32'h2);
    tick();
    chk("lk_valid_bubble", 32'(ifb.out_valid), 32'h0);
    ifb.in_data[8 +: 8] = 8'hB2;
    ifb.in_valid = 4'b0110;
    #1;
    chk("lk_ready_b2", 32'(ifb.in_ready), 32'h2);
    tick();
    chk("lk_sel_b2",  32'(ifb.out_sel),  32'h1);
    chk("lk_data_b2", 32'(ifb.out_data), 32'hB2);
    ifb.in_data[8 +: 8] = 8'hB3;
    ifb.in_last  = 4'b0110;
    #1;
    chk("lk_ready_b3", 32'(ifb.in_ready), 32'h2);
    tick();
    chk("lk_sel_b3",  32'(ifb.out_sel),  32'h1);
    chk("lk_data_b3", 32'(ifb.out_data), 32'hB3);
    chk("lk_last_b3", 32'(ifb.out_last), 32'h1);
    ifb.in_valid = 4'b0100;
    #1;
    chk("lk_ready_c2", 32'(ifb.in_ready), 32'h4);
    tick();
    chk("lk_valid_c2", 32'(ifb.out_valid), 32'h1);
    chk("lk_sel_c2",   32'(ifb.out_sel),   32'h2);
    chk("lk_data_c2",  32'(ifb.out_data),  32'hC2);

    // ---------------- Backpressure (B) ----------------------------------
    ifb.in_data[24 +: 8] = 8'hA5;
    ifb.in_last  = 4'b1000;
    ifb.in_valid = 4'b1000;
    #1;
    chk("bp_ready_a5", 32'(ifb.in_ready), 32'h8);
    tick();
    chk("bp_valid_a5", 32'(ifb.out_valid), 32'h1);
    chk("bp_data_a5",  32'(ifb.out_data),  32'hA5);
    ifb.out_ready = 1'b0;
    ifb.in_data[0 +: 8] = 8'h77;
    ifb.in_last  = 4'b0001;
    ifb.in_valid = 4'b0001;
    #1;
    chk("bp_ready_hold0", 32'(ifb.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_valid_hold%0d", k), 32'(ifb.out_valid), 32'h1);
      chk($sformatf("bp_data_hold%0d", k),  32'(ifb.out_data),  32'hA5);
      chk($sformatf("bp_sel_hold%0d", k),   32'(ifb.out_sel),   32'h3);
      chk($sformatf("bp_ready_hold%0d", k), 32'(ifb.in_ready),  32'h0);
    end
    ifb.out_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(ifb.in_ready), 32'h1);
    tick();
    chk("bp_valid_next", 32'(ifb.out_valid), 32'h1);
    chk("bp_data_next",  32'(ifb.out_data),  32'h77);
    chk("bp_sel_next",   32'(ifb.out_sel),   32'h0);
    ifb.in_valid = '0;
    tick();
    chk("bp_drained", 32'(ifb.out_valid), 32'h0);

    // ---------------- Reset mid-packet on ch0 (B, rr_ptr = 1) ------------
    ifb.in_data[0 +: 8] = 8'hD1;
    ifb.in_last  = 4'b0000;
    ifb.in_valid = 4'b0001;
    #1;
    chk("mr_ready_d1", 32'(ifb.in_ready), 32'h1);
    tick();
    chk("mr_data_d1", 32'(ifb.out_data), 32'hD1);
    chk("mr_last_d1", 32'(ifb.out_last), 32'h0);
    rst = 1'b1;
    ifb.in_data[0 +: 8] = 8'hD2;
    #1;
    chk("mr_ready_in_rst", 32'(ifb.in_ready), 32'h0);
    tick();
    chk("mr_valid_rst", 32'(ifb.out_valid), 32'h0);
    chk("mr_sel_rst",   32'(ifb.out_sel),   32'h0);
    chk("mr_data_rst",  32'(ifb.out_data),  32'h0);
    rst = 1'b0;
    ifb.in_data[0 +: 8] = 8'hF0;
    ifb.in_data[8 +: 8] = 8'hF1;
    ifb.in_last  = 4'b0011;
    ifb.in_valid = 4'b0011;
    #1;
    chk("mr_ready_ch0", 32'(ifb.in_ready), 32'h1);
    tick();
    chk("mr_valid_f0", 32'(ifb.out_valid), 32'h1);
    chk("mr_data_f0",  32'(ifb.out_data),  32'hF0);
    chk("mr_sel_f0",   32'(ifb.out_sel),   32'h0);
    ifb.in_valid = 4'b0010;
    #1;
    chk("mr_ready_ch1", 32'(ifb.in_ready), 32'h2);
    tick();
    chk("mr_data_f1", 32'(ifb.out_data), 32'hF1);
    chk("mr_sel_f1",  32'(ifb.out_sel),  32'h1);
    ifb.in_valid = '0;

    // ---------------- External select (C, N=5) --------------------------
    ifc.in_data  = {8'h4D, 8'h53, 8'h3C, 8'h51, 8'h50};
    ifc.in_last  = 5'b11111;
    ifc.in_valid = 5'b11111;
    ifc.sel      = 3'd2;
    #1;
    chk("sel2_ready", 32'(ifc.in_ready), 32'h4);
    tick();
    chk("sel2_valid", 32'(ifc.out_valid), 32'h1);
    chk("sel2_data",  32'(ifc.out_data),  32'h3C);
    chk("sel2_sel",   32'(ifc.out_sel),   32'h2);
    ifc.sel = 3'd7;
    #1;
    chk("sel7_ready", 32'(ifc.in_ready), 32'h0);
    tick();
    chk("sel7_valid", 32'(ifc.out_valid), 32'h0);
    ifc.sel = 3'd4;
    #1;
    chk("sel4_ready", 32'(ifc.in_ready), 32'h10);
    tick();
    chk("sel4_valid", 32'(ifc.out_valid), 32'h1);
    chk("sel4_data",  32'(ifc.out_data),  32'h4D);
    chk("sel4_sel",   32'(ifc.out_sel),   32'h4);
    ifc.in_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
